// File: rtl/sobel_accel_pipe_if.sv
// rtl/sobel_accel_pipe_if.sv - valid/ready input and output bundle of the pipelined Sobel accelerator
interface sobel_accel_pipe_if #(
    parameter int NUM_CORES = 8,
    parameter int PIX_W     = 8
);
    logic                              in_valid;
    logic                              in_ready;
    logic [(NUM_CORES+2)*PIX_W-1:0]    in_row1;
    logic [(NUM_CORES+2)*PIX_W-1:0]    in_row2;
    logic [(NUM_CORES+2)*PIX_W-1:0]    in_row3;
    logic [1:0]                        in_mode;
    logic [PIX_W-1:0]                  in_thresh;
    logic                              out_valid;
    logic                              out_ready;
    logic [NUM_CORES*PIX_W-1:0]        out_data;

    // Source of input beats and sink of results (row-register block / write path side)
    modport master (
        output in_valid, in_row1, in_row2, in_row3, in_mode, in_thresh, out_ready,
        input  in_ready, out_valid, out_data
    );

    // The accelerator itself
    modport slave (
        input  in_valid, in_row1, in_row2, in_row3, in_mode, in_thresh, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/sobel_accel_pipe.sv
// rtl/sobel_accel_pipe.sv - two-stage pipelined NUM_CORES-wide Sobel engine with sum/max/threshold modes
module sobel_accel_pipe #(
    parameter int NUM_CORES = 8,
    parameter int PIX_W     = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    sobel_accel_pipe_if.slave   bus,
    output logic [31:0]         beat_count
);
    localparam int ROW_W = (NUM_CORES + 2) * PIX_W;
    // Signed working width: 4*(2^PIX_W-1) plus sign fits in PIX_W+4 bits
    localparam int SW    = PIX_W + 4;
    localparam logic [PIX_W-1:0] MAX = '1;

    // Zero-extend pixel k of a row into the signed working width
    function automatic logic signed [SW-1:0] px(input logic [ROW_W-1:0] row, input int k);
        return $signed({{(SW-PIX_W){1'b0}}, row[k*PIX_W +: PIX_W]});
    endfunction

    // |v| clipped to the pixel range
    function automatic logic [PIX_W-1:0] abs_sat(input logic signed [SW-1:0] v);
        logic [SW-1:0] m;
        m = (v < 0) ? $unsigned(-v) : $unsigned(v);
        return (m > {{(SW-PIX_W){1'b0}}, MAX}) ? MAX : m[PIX_W-1:0];
    endfunction

    // Horizontal-edge gradient: top row minus bottom row, [1 2 1] weighted
    function automatic logic signed [SW-1:0] grad_x(input logic [ROW_W-1:0] r1,
                                                    input logic [ROW_W-1:0] r3, input int c);
        return (px(r1, c+2) + (px(r1, c+1) <<< 1) + px(r1, c))
             - (px(r3, c+2) + (px(r3, c+1) <<< 1) + px(r3, c));
    endfunction

    // Vertical-edge gradient: right column minus left column, [1 2 1] weighted
    function automatic logic signed [SW-1:0] grad_y(input logic [ROW_W-1:0] r1,
                                                    input logic [ROW_W-1:0] r2,
                                                    input logic [ROW_W-1:0] r3, input int c);
        return (px(r1, c+2) + (px(r2, c+2) <<< 1) + px(r3, c+2))
             - (px(r1, c)   + (px(r2, c)   <<< 1) + px(r3, c));
    endfunction

    logic                                s1_en;
    logic                                s2_en;

    logic                                s1_valid_q;
    logic [NUM_CORES-1:0][PIX_W-1:0]     gxs_d;
    logic [NUM_CORES-1:0][PIX_W-1:0]     gys_d;
    logic [NUM_CORES-1:0][PIX_W-1:0]     gxs_q;
    logic [NUM_CORES-1:0][PIX_W-1:0]     gys_q;
    logic [1:0]                          mode_q;
    logic [PIX_W-1:0]                    thresh_q;

    logic                                out_valid_q;
    logic [NUM_CORES*PIX_W-1:0]          out_data_d;
    logic [NUM_CORES*PIX_W-1:0]          out_data_q;

    logic [31:0]                         beat_count_d;
    logic [31:0]                         beat_count_q;

    // A stage may load when it is empty or its contents move on this cycle
    assign s2_en        = !out_valid_q || bus.out_ready;
    assign s1_en        = !s1_valid_q || s2_en;
    assign bus.in_ready = s1_en;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign beat_count    = beat_count_q;

    // Stage 1 datapath: saturated gradient magnitudes for every core
    always_comb begin
        gxs_d = '0;
        gys_d = '0;
        for (int c = 0; c < NUM_CORES; c++) begin
            gxs_d[c] = abs_sat(grad_x(bus.in_row1, bus.in_row3, c));
            gys_d[c] = abs_sat(grad_y(bus.in_row1, bus.in_row2, bus.in_row3, c));
        end
    end

    // Stage 1 register: magnitudes plus the mode/threshold that travel with this beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            gxs_q      <= '0;
            gys_q      <= '0;
            mode_q     <= '0;
            thresh_q   <= '0;
        end else if (s1_en) begin
            s1_valid_q <= bus.in_valid;
            gxs_q      <= gxs_d;
            gys_q      <= gys_d;
            mode_q     <= bus.in_mode;
            thresh_q   <= bus.in_thresh;
        end
    end

    // Stage 2 datapath: combine magnitudes according to the beat's mode (3 falls back to sum)
    always_comb begin
        out_data_d = '0;
        for (int c = 0; c < NUM_CORES; c++) begin
            logic [PIX_W:0]   sum;
            logic [PIX_W-1:0] sat_sum;
            logic [PIX_W-1:0] lane;
            sum     = {1'b0, gxs_q[c]} + {1'b0, gys_q[c]};
            sat_sum = sum[PIX_W] ? MAX : sum[PIX_W-1:0];
            case (mode_q)
                2'd1:    lane = (gxs_q[c] > gys_q[c]) ? gxs_q[c] : gys_q[c];
                2'd2:    lane = (sat_sum >= thresh_q) ? MAX : '0;
                default: lane = sat_sum;
            endcase
            out_data_d[c*PIX_W +: PIX_W] = lane;
        end
    end

    // Stage 2 register: holds the result steady while downstream stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else if (s2_en) begin
            out_valid_q <= s1_valid_q;
            out_data_q  <= out_data_d;
        end
    end

    // Completed output handshakes, wrapping naturally at 2^32
    always_comb begin
        beat_count_d = beat_count_q;
        if (out_valid_q && bus.out_ready) begin
            beat_count_d = beat_count_q + 32'd1;
        end
    end

    // Output beat counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_count_q <= '0;
        end else begin
            beat_count_q <= beat_count_d;
        end
    end
endmodule

// File: tb/tb_sobel_accel_pipe.sv
// tb/tb_sobel_accel_pipe.sv - scoreboard bench for sobel_accel_pipe
module tb_sobel_accel_pipe;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] beat_count;

    int checks = 0;
    int fails  = 0;
    bit rand_bp = 1'b0;
    logic [63:0] exp_q[$];

    sobel_accel_pipe_if #(.NUM_CORES(8), .PIX_W(8)) bif ();

    sobel_accel_pipe #(.NUM_CORES(8), .PIX_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bif),
        .beat_count (beat_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (rand_bp) bif.out_ready = 1'($urandom_range(0, 1));
    endtask

    function automatic logic [79:0] mk_row(input int base, input int stp);
        logic [79:0] r;
        r = '0;
        for (int k = 0; k < 10; k++) r[k*8 +: 8] = 8'(base + stp * k);
        return r;
    endfunction

    function automatic logic [79:0] mk_edge();
        logic [79:0] r;
        r = '0;
        for (int k = 5; k < 10; k++) r[k*8 +: 8] = 8'hFF;
        return r;
    endfunction

    function automatic logic [63:0] model(input logic [79:0] r1, input logic [79:0] r2,
                                          input logic [79:0] r3, input logic [1:0] m,
                                          input logic [7:0] th);
        logic [63:0] o;
        o = '0;
        for (int c = 0; c < 8; c++) begin
            int a0, a1, a2, b0, b2, d0, d1, d2, gx, gy, ax, ay, s, lane;
            a0 = int'(r1[c*8 +: 8]);      a1 = int'(r1[(c+1)*8 +: 8]); a2 = int'(r1[(c+2)*8 +: 8]);
            b0 = int'(r2[c*8 +: 8]);      b2 = int'(r2[(c+2)*8 +: 8]);
            d0 = int'(r3[c*8 +: 8]);      d1 = int'(r3[(c+1)*8 +: 8]); d2 = int'(r3[(c+2)*8 +: 8]);
            gx = (a0 + 2*a1 + a2) - (d0 + 2*d1 + d2);
            gy = (a2 + 2*b2 + d2) - (a0 + 2*b0 + d0);
            ax = (gx < 0) ? -gx : gx;  if (ax > 255) ax = 255;
            ay = (gy < 0) ? -gy : gy;  if (ay > 255) ay = 255;
            s  = ax + ay;              if (s > 255) s = 255;
            case (m)
                2'd1:    lane = (ax > ay) ? ax : ay;
                2'd2:    lane = (s >= int'(th)) ? 255 : 0;
                default: lane = s;
            endcase
            o[c*8 +: 8] = lane[7:0];
        end
        return o;
    endfunction

    task automatic send(input logic [79:0] r1, input logic [79:0] r2, input logic [79:0] r3,
                        input logic [1:0] m, input logic [7:0] th, input logic [63:0] req);
        bit done;
        done = 1'b0;
        bif.in_valid  = 1'b1;
        bif.in_row1   = r1;
        bif.in_row2   = r2;
        bif.in_row3   = r3;
        bif.in_mode   = m;
        bif.in_thresh = th;
        for (int t = 0; t < 200 && !done; t++) begin
            @(negedge clk);
            if (bif.in_ready) begin
                exp_q.push_back(req);
                done = 1'b1;
            end
            step();
        end
        if (!done) chk("send_timeout", 64'd0, 64'd1);
    endtask

    task automatic drain();
        for (int t = 0; t < 300 && exp_q.size() != 0; t++) step();
        chk("drain_left", 64'(exp_q.size()), 64'd0);
        step();
        step();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        exp_q.delete();
        bif.in_valid = 1'b0;
        #1;
        chk("rst_out_valid", 64'(bif.out_valid), 64'd0);
        chk("rst_beat_count", 64'(beat_count), 64'd0);
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            if (rst_n && bif.out_valid && bif.out_ready) begin
                if (exp_q.size() == 0) chk("unexpected_output", bif.out_data, 64'hx);
                else chk("out_data", bif.out_data, exp_q.pop_front());
            end
        end
    endtask

    task automatic main_seq();
        logic [79:0] g1, g2, g3, e, r1, r2, r3;
        logic [63:0] held;
        logic [1:0]  m;
        logic [7:0]  th;
        g1 = mk_row(16, 4);
        g2 = mk_row(8, 4);
        g3 = mk_row(0, 4);
        e  = mk_edge();

        bif.in_valid  = 1'b0;
        bif.in_row1   = '0;
        bif.in_row2   = '0;
        bif.in_row3   = '0;
        bif.in_mode   = 2'd0;
        bif.in_thresh = 8'd0;
        bif.out_ready = 1'b1;

        // Reset with in_valid high
        #2;
        rst_n = 1'b0;
        bif.in_valid = 1'b1;
        bif.in_row1 = g1; bif.in_row2 = g2; bif.in_row3 = g3;
        #1;
        chk("reset_out_valid", 64'(bif.out_valid), 64'd0);
        chk("reset_out_data", bif.out_data, 64'd0);
        chk("reset_beat_count", 64'(beat_count), 64'd0);
        chk("reset_in_ready", 64'(bif.in_ready), 64'd1);
        step();
        step();
        chk("reset_in_ready_held", 64'(bif.in_ready), 64'd1);
        chk("reset_out_valid_held", 64'(bif.out_valid), 64'd0);
        rst_n = 1'b1;
        send(g1, g2, g3, 2'd0, 8'd0, 64'h6060606060606060);
        bif.in_valid = 1'b0;
        chk("latency_edge1", 64'(bif.out_valid), 64'd0);
        step();
        chk("latency_edge2", 64'(bif.out_valid), 64'd1);
        drain();

        // Vertical edge and gradient in every mode
        send(e, e, e, 2'd0, 8'd0, 64'h000000FFFF000000);
        send(g1, g2, g3, 2'd0, 8'd0,  64'h6060606060606060);
        send(g1, g2, g3, 2'd1, 8'd0,  64'h4040404040404040);
        send(g1, g2, g3, 2'd2, 8'd80, 64'hFFFFFFFFFFFFFFFF);
        send(g1, g2, g3, 2'd2, 8'd97, 64'h0000000000000000);
        send(g1, g2, g3, 2'd3, 8'd0,  64'h6060606060606060);
        bif.in_valid = 1'b0;
        drain();

        // Per-beat mode sampling, back-to-back
        send(g1, g2, g3, 2'd0, 8'd0, 64'h6060606060606060);
        send(g1, g2, g3, 2'd1, 8'd0, 64'h4040404040404040);
        chk("b2b_valid_1", 64'(bif.out_valid), 64'd1);
        send(g1, g2, g3, 2'd0, 8'd0, 64'h6060606060606060);
        chk("b2b_valid_2", 64'(bif.out_valid), 64'd1);
        bif.in_valid = 1'b0;
        step();
        chk("b2b_valid_3", 64'(bif.out_valid), 64'd1);
        step();
        chk("b2b_valid_end", 64'(bif.out_valid), 64'd0);
        drain();

        // Backpressure: two beats fill the pipe, third waits
        do_reset();
        bif.out_ready = 1'b0;
        send(g1, g2, g3, 2'd0, 8'd0,  64'h6060606060606060);
        send(g1, g2, g3, 2'd1, 8'd0,  64'h4040404040404040);
        bif.in_mode = 2'd2;
        bif.in_thresh = 8'd80;
        for (int t = 0; t < 3; t++) begin
            @(negedge clk);
            chk("bp_in_ready", 64'(bif.in_ready), 64'd0);
            chk("bp_out_valid", 64'(bif.out_valid), 64'd1);
            chk("bp_out_data_stable", bif.out_data, 64'h6060606060606060);
            step();
        end
        held = bif.out_data;
        chk("bp_beat_count_stall", 64'(beat_count), 64'd0);
        bif.out_ready = 1'b1;
        send(g1, g2, g3, 2'd2, 8'd80, 64'hFFFFFFFFFFFFFFFF);
        bif.in_valid = 1'b0;
        drain();
        chk("bp_beat_count", 64'(beat_count), 64'd3);
        chk("bp_held_first", held, 64'h6060606060606060);

        // Random stimulus with random backpressure and a mid-stream reset
        rand_bp = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (i == 20) begin
                do_reset();
                chk("midrst_beat_count", 64'(beat_count), 64'd0);
            end
            if ($urandom_range(0, 3) == 0) begin
                bif.in_valid = 1'b0;
                step();
            end
            r1 = {16'($urandom), $urandom, $urandom};
            r2 = {16'($urandom), $urandom, $urandom};
            r3 = {16'($urandom), $urandom, $urandom};
            m  = 2'($urandom_range(0, 3));
            th = 8'($urandom);
            send(r1, r2, r3, m, th, model(r1, r2, r3, m, th));
        end
        bif.in_valid = 1'b0;
        rand_bp = 1'b0;
        bif.out_ready = 1'b1;
        drain();
        chk("final_out_valid", 64'(bif.out_valid), 64'd0);
    endtask

    initial begin
        fork
            monitor();
            main_seq();
        join_any
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
